// File: rtl/hbus_wb_bridge_if.sv
// hbus_wb_bridge_if: Wishbone slave bus plus hyperbus controller request port
interface hbus_wb_bridge_if #(
  parameter int ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0] wb_sel_i;
  logic wb_we_i;
  logic wb_cyc_i;
  logic wb_stb_i;
  logic wb_ack_o;
  logic wb_err_o;
  logic [31:0] hb_addr;
  logic [15:0] hb_dout;
  logic [15:0] hb_din;
  logic hb_wrq;
  logic hb_rrq;
  logic hb_busy;
  modport slave (
    input wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, hb_din, hb_busy,
    output wb_dat_o, wb_ack_o, wb_err_o, hb_addr, hb_dout, hb_wrq, hb_rrq
  );
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, hb_din, hb_busy,
    input wb_dat_o, wb_ack_o, wb_err_o, hb_addr, hb_dout, hb_wrq, hb_rrq
  );
endinterface

// File: rtl/hbus_wb_bridge.sv
// hbus_wb_bridge: splits 32-bit Wishbone accesses into 16-bit hyperbus controller requests
module hbus_wb_bridge #(
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst,
  hbus_wb_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE, ERR} state_t;
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, nxt;
  logic [WW-1:0] wd;
  logic [30:0] base;
  logic [31:0] dat, rdata;
  logic [3:0] sel;
  logic we, err_q, start, bad, hi, req, tmo, lo_only, unused;
  assign unused = ^bus.wb_adr_i[1:0];
  always_comb begin
    start = bus.wb_cyc_i & bus.wb_stb_i & ~bus.hb_busy;
    bad = bus.wb_we_i & ~(bus.wb_sel_i inside {4'hf, 4'h3, 4'hc});
    req = state == REQ_LO || state == REQ_HI;
    hi = state == REQ_HI || state == WAIT_HI;
    tmo = TIMEOUT != 0 && wd == WW'(TIMEOUT - 1);
    lo_only = we && sel == 4'h3;
    nxt = state;
    case (state)
      IDLE:    nxt = !start ? IDLE : bad ? ERR : (bus.wb_we_i && bus.wb_sel_i == 4'hc) ? REQ_HI : REQ_LO;
      REQ_LO:  nxt = bus.hb_busy ? WAIT_LO : tmo ? ERR : REQ_LO;
      WAIT_LO: nxt = !bus.hb_busy ? (lo_only ? DONE : REQ_HI) : tmo ? ERR : WAIT_LO;
      REQ_HI:  nxt = bus.hb_busy ? WAIT_HI : tmo ? ERR : REQ_HI;
      WAIT_HI: nxt = !bus.hb_busy ? DONE : tmo ? ERR : WAIT_HI;
      DONE:    nxt = IDLE;
      ERR:     nxt = bus.hb_busy ? ERR : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wd <= '0;
      base <= '0;
      dat <= '0;
      rdata <= '0;
      sel <= '0;
      we <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= state == ERR;
      wd <= (state == IDLE || (nxt == REQ_HI && state != REQ_HI)) ? '0 : wd + 1'b1;
      if (state == IDLE && start) begin
        base <= 31'(bus.wb_adr_i[ADDR_WIDTH-1:2]);
        dat <= bus.wb_dat_i;
        sel <= bus.wb_sel_i;
        we <= bus.wb_we_i;
      end
      if (state == WAIT_LO && !bus.hb_busy && !we) rdata[15:0] <= bus.hb_din;
      if (state == WAIT_HI && !bus.hb_busy && !we) rdata[31:16] <= bus.hb_din;
    end
  end
  // err_q limits the error strobe to the first ERR cycle while draining a stuck controller
  assign bus.hb_wrq = req & we;
  assign bus.hb_rrq = req & ~we;
  assign bus.hb_addr = {base, hi};
  assign bus.hb_dout = hi ? dat[31:16] : dat[15:0];
  assign bus.wb_ack_o = state == DONE && bus.wb_cyc_i;
  assign bus.wb_err_o = state == ERR && !err_q && bus.wb_cyc_i;
  assign bus.wb_dat_o = rdata;
endmodule

// File: tb/tb_hbus_wb_bridge.sv
// tb_hbus_wb_bridge: vector table, corner sequences and random accesses against a controller model
module tb_hbus_wb_bridge;
  localparam int TMO = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hbus_wb_bridge_if #(.ADDR_WIDTH(24)) bus();
  hbus_wb_bridge #(.ADDR_WIDTH(24), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic w; logic [31:0] a; logic [15:0] d;} tx_t;
  typedef struct {bit we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; int tb; bit chk_rd; logic [31:0] rd;} vec_t;
  tx_t act_q[$];
  tx_t exp_q[$];
  logic [15:0] mem [0:2047];
  logic [15:0] shadow [0:2047];
  logic m_busy = 1'b0;
  logic hold_busy = 1'b0;
  logic never_busy = 1'b0;
  logic [15:0] m_din = 16'h0;
  int tbusy = 1;
  int bcnt = 0;
  int checks = 0;
  int errors = 0;
  assign bus.hb_busy = m_busy | hold_busy;
  assign bus.hb_din = m_din;

  function automatic tx_t mk(logic w, logic [31:0] a, logic [15:0] d);
    return {w, a, d};
  endfunction

  // controller: accepts one cycle after a request, then stays busy for tbusy cycles
  always @(posedge clk) begin
    if (m_busy) begin
      if (bcnt <= 1) m_busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end else if ((bus.hb_wrq || bus.hb_rrq) && !never_busy && !hold_busy) begin
      m_busy <= 1'b1;
      bcnt <= tbusy;
      act_q.push_back(mk(bus.hb_wrq, bus.hb_addr, bus.hb_wrq ? bus.hb_dout : 16'h0));
      if (bus.hb_wrq) mem[bus.hb_addr[10:0]] = bus.hb_dout;
      else m_din <= mem[bus.hb_addr[10:0]];
    end
  end

  always @(negedge clk)
    if (!rst && ((bus.hb_wrq && bus.hb_rrq) || (bus.wb_ack_o && bus.wb_err_o))) begin
      errors++;
      $display("FAIL exclusive: wrq=%b rrq=%b ack=%b err=%b, required no two at once",
               bus.hb_wrq, bus.hb_rrq, bus.wb_ack_o, bus.wb_err_o);
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  task automatic chk_tx(input string name);
    bit ok;
    tx_t fa;
    tx_t fe;
    ok = act_q.size() == exp_q.size();
    for (int i = 0; ok && i < act_q.size(); i++) ok = act_q[i] === exp_q[i];
    fa = '0;
    fe = '0;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) begin
        fa = act_q[i];
        fe = exp_q[i];
        break;
      end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d ops (diff w=%0d a=%h d=%h), required %0d ops (w=%0d a=%h d=%h)",
               name, act_q.size(), fa.w, fa.a, fa.d, exp_q.size(), fe.w, fe.a, fe.d);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // reference: word address A = adr/2 rounded to even, halves at A and A+1
  task automatic predict(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output bit exp_err, output logic [31:0] exp_rd);
    logic [31:0] a;
    logic [31:0] b;
    a = (adr >> 1) & ~32'h1;
    b = a + 1;
    exp_rd = 32'h0;
    exp_err = we && !(sel == 4'hf || sel == 4'h3 || sel == 4'hc);
    if (!exp_err && we) begin
      if (sel[0]) begin
        exp_q.push_back(mk(1'b1, a, dat[15:0]));
        shadow[a[10:0]] = dat[15:0];
      end
      if (sel[3]) begin
        exp_q.push_back(mk(1'b1, b, dat[31:16]));
        shadow[b[10:0]] = dat[31:16];
      end
    end else if (!exp_err) begin
      exp_q.push_back(mk(1'b0, a, 16'h0));
      exp_q.push_back(mk(1'b0, b, 16'h0));
      exp_rd = {shadow[b[10:0]], shadow[a[10:0]]};
    end
  endtask

  task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output bit ack, output bit err,
                           output logic [31:0] rd, output int n);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = we;
    bus.wb_adr_i = adr[23:0];
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    ack = 1'b0;
    err = 1'b0;
    rd = 32'h0;
    n = 0;
    while (!ack && !err && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      ack = bus.wb_ack_o;
      err = bus.wb_err_o;
      rd = bus.wb_dat_o;
    end
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic run(input string tag, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int tb);
    bit exp_err;
    bit ack;
    bit err;
    logic [31:0] exp_rd;
    logic [31:0] rd;
    int n;
    predict(we, adr, dat, sel, exp_err, exp_rd);
    tbusy = tb;
    wb_access(we, adr, dat, sel, ack, err, rd, n);
    chk({tag, " ack/err"}, {30'h0, ack, err}, {30'h0, !exp_err, exp_err});
    chk_tx({tag, " ops"});
    if (!we && !exp_err) chk({tag, " rdata"}, rd, exp_rd);
    if (exp_err) chk({tag, " err latency"}, n, 1);
    else if (!we || sel == 4'hf) chk({tag, " latency"}, n, 2 * (2 + tb) + 1);
    last_rd = rd;
  endtask

  logic [31:0] last_rd;
  vec_t vt[10];

  initial begin
    bit ack;
    bit err;
    bit exp_err;
    logic [31:0] rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    int n;
    int got;
    int acks;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 16'(i * 311) ^ 16'h5a5a;
      shadow[i] = 16'(i * 311) ^ 16'h5a5a;
    end
    mem[16] = 16'h1234;
    mem[17] = 16'habcd;
    shadow[16] = 16'h1234;
    shadow[17] = 16'habcd;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    vt[0] = '{0, 32'h20, 32'h0, 4'hf, 1, 1, 32'habcd1234};
    vt[1] = '{1, 32'h10, 32'hdeadbeef, 4'hf, 1, 0, 32'h0};
    vt[2] = '{0, 32'h10, 32'h0, 4'hf, 3, 1, 32'hdeadbeef};
    vt[3] = '{1, 32'h4, 32'h5555aaaa, 4'hc, 2, 0, 32'h0};
    vt[4] = '{1, 32'h4, 32'h12345678, 4'h6, 1, 0, 32'h0};
    vt[5] = '{0, 32'h4, 32'h0, 4'h1, 1, 0, 32'h0};
    vt[6] = '{1, 32'h8, 32'h11112222, 4'h3, 2, 0, 32'h0};
    vt[7] = '{0, 32'h8, 32'h0, 4'hc, 1, 0, 32'h0};
    vt[8] = '{1, 32'h8, 32'hffffffff, 4'h1, 1, 0, 32'h0};
    vt[9] = '{1, 32'h8, 32'hffffffff, 4'h0, 1, 0, 32'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl", {28'h0, bus.hb_wrq, bus.hb_rrq, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
    chk("reset dat_o", bus.wb_dat_o, 32'h0);
    chk("reset addr", bus.hb_addr, 32'h0);
    chk("reset dout", {16'h0, bus.hb_dout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run($sformatf("vec%0d", i), vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, vt[i].tb);
      if (vt[i].chk_rd) chk($sformatf("vec%0d const rdata", i), last_rd, vt[i].rd);
    end
    never_busy = 1'b1;
    wb_access(1'b1, 32'h40, 32'h01020304, 4'hf, ack, err, rd, n);
    chk("wdog ack/err", {30'h0, ack, err}, 32'h1);
    chk("wdog latency within bound", {31'h0, n >= TMO && n <= TMO + 1}, 32'h1);
    chk("wdog request dropped", {31'h0, bus.hb_wrq}, 32'h0);
    chk_tx("wdog ops");
    never_busy = 1'b0;
    run("after wdog wr", 1'b1, 32'h40, 32'h0badcafe, 4'hf, 1);
    run("after wdog rd", 1'b0, 32'h40, 32'h0, 4'hf, 2);
    predict(1'b1, 32'h80, 32'hcafef00d, 4'hf, exp_err, rd);
    tbusy = 2;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 24'h80;
    bus.wb_dat_i = 32'hcafef00d;
    bus.wb_sel_i = 4'hf;
    repeat (3) @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o || bus.wb_err_o) acks++;
    end
    chk("cyc drop no ack", acks, 0);
    chk_tx("cyc drop ops");
    run("cyc drop readback", 1'b0, 32'h80, 32'h0, 4'hf, 1);
    predict(1'b0, 32'h100, 32'h0, 4'hf, exp_err, exp1);
    predict(1'b0, 32'h104, 32'h0, 4'hf, exp_err, exp2);
    tbusy = 1;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 24'h100;
    bus.wb_sel_i = 4'hf;
    got = 0;
    n = 0;
    rd1 = 32'h0;
    rd2 = 32'h0;
    while (got < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.wb_ack_o) begin
        got++;
        if (got == 1) rd1 = bus.wb_dat_o;
        else rd2 = bus.wb_dat_o;
        @(negedge clk);
        bus.wb_adr_i = 24'h104;
        if (got == 2) begin
          bus.wb_cyc_i = 1'b0;
          bus.wb_stb_i = 1'b0;
        end
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    chk("b2b acks", got, 2);
    chk("b2b rdata1", rd1, exp1);
    chk("b2b rdata2", rd2, exp2);
    chk_tx("b2b ops");
    repeat (10) @(posedge clk);
    chk("b2b no extra op", act_q.size(), 0);
    predict(1'b0, 32'h200, 32'h0, 4'hf, exp_err, rd);
    tbusy = 6;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 24'h200;
    n = 0;
    while (act_q.size() < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_tx("rst seq ops before reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    hold_busy = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rst seq ctl", {28'h0, bus.hb_wrq, bus.hb_rrq, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
    chk("rst seq dat_o", bus.wb_dat_o, 32'h0);
    chk("rst seq addr", bus.hb_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    predict(1'b0, 32'h204, 32'h0, 4'hf, exp_err, exp1);
    tbusy = 1;
    fork
      wb_access(1'b0, 32'h204, 32'h0, 4'hf, ack, err, rd, n);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("rst seq no request while busy", {act_q.size() != 0, bus.hb_rrq}, 32'h0);
        hold_busy = 1'b0;
      end
    join
    chk("rst seq new read ack", {30'h0, ack, err}, 32'h2);
    chk("rst seq new read rdata", rd, exp1);
    chk_tx("rst seq new read ops");
    for (int i = 0; i < 40; i++) begin
      logic [3:0] sel;
      int r;
      r = $urandom_range(0, 3);
      sel = r == 0 ? 4'hf : r == 1 ? 4'h3 : r == 2 ? 4'hc : 4'($urandom);
      run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)) & 32'hffc,
          32'($urandom), sel, $urandom_range(1, 4));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
